// File: rtl/dcs_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcs_sel_ctrl
// Purpose  : Control-side sequencer for one LIFCL DCS (dynamic clock select)
//            site. Turns valid/ready switch requests into SEL / SELFORCE
//            updates. Each switch is followed by a settle window and then a
//            minimum dwell before the next request is taken. If either the
//            target clock or the current clock is reported dead when a
//            request is accepted, the switch falls back to SELFORCE.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i           in   control clock, all logic on rising edge
//   rst_n_i         in   synchronous reset, active low
//   req_valid_i     in   switch request valid
//   req_ready_o     out  high in IDLE; a request is taken on valid & ready
//   req_sel_i       in   target clock input (0 = CLK0, 1 = CLK1)
//   req_force_i     in   1: switch using SELFORCE (no glitch-free handshake)
//   clk0_alive_i    in   synchronised liveness flag for DCS CLK0
//   clk1_alive_i    in   synchronised liveness flag for DCS CLK1
//   dcs_sel_o       out  to DCS SEL
//   dcs_selforce_o  out  to DCS SELFORCE
//   busy_o          out  high while a switch is in progress (state != IDLE)
//   done_o          out  one-cycle pulse when a switch completes
//   forced_o        out  sticky: last completed switch used SELFORCE,
//                        cleared when the next request is accepted
// ============================================================================
module dcs_sel_ctrl #(
   parameter int   SETTLE_CYCLES = 8,
   parameter int   DWELL_CYCLES  = 16,
   parameter int   CNT_W         = 8,
   parameter logic INIT_SEL      = 1'b0
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic req_valid_i,
   output logic req_ready_o,
   input  logic req_sel_i,
   input  logic req_force_i,
   input  logic clk0_alive_i,
   input  logic clk1_alive_i,
   output logic dcs_sel_o,
   output logic dcs_selforce_o,
   output logic busy_o,
   output logic done_o,
   output logic forced_o
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam logic [CNT_W-1:0] C_SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_DWELL_LOAD  = CNT_W'(DWELL_CYCLES);
   localparam logic [CNT_W-1:0] C_CNT_ZERO    = '0;
   localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);
   localparam logic             C_SKIP_DWELL  = (DWELL_CYCLES == 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SWITCH = 2'd1,
      ST_SETTLE = 2'd2,
      ST_DWELL  = 2'd3
   } state_t;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_t           state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic             sel_q,      sel_d;
   logic             selforce_q, selforce_d;
   logic             done_q,     done_d;
   logic             forced_q,   forced_d;
   logic             tgt_q,      tgt_d;      // latched target clock
   logic             frc_q,      frc_d;      // latched force decision

   logic w_alive_tgt;
   logic w_alive_cur;
   logic w_force_req;

   // Liveness only matters at the accept instant; the decision is latched
   // into frc_q so later liveness changes cannot alter an in-flight switch.
   assign w_alive_tgt = req_sel_i ? clk1_alive_i : clk0_alive_i;
   assign w_alive_cur = sel_q     ? clk1_alive_i : clk0_alive_i;
   assign w_force_req = req_force_i | ~w_alive_tgt | ~w_alive_cur;

   // -------------------------------------------------------------------------
   // Next-state / output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sel_d      = sel_q;
      selforce_d = selforce_q;
      done_d     = 1'b0;
      forced_d   = forced_q;
      tgt_d      = tgt_q;
      frc_d      = frc_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               tgt_d    = req_sel_i;
               frc_d    = w_force_req;
               forced_d = 1'b0;
               if ((req_sel_i == sel_q) && !w_force_req) begin
                  // Already on the requested clock: complete immediately,
                  // but still honour the dwell before the next request.
                  done_d = 1'b1;
                  if (C_SKIP_DWELL) begin
                     state_d = ST_IDLE;
                     cnt_d   = C_CNT_ZERO;
                  end else begin
                     state_d = ST_DWELL;
                     cnt_d   = C_DWELL_LOAD;
                  end
               end else begin
                  state_d = ST_SWITCH;
               end
            end
         end

         ST_SWITCH: begin
            sel_d      = tgt_q;
            selforce_d = frc_q;
            forced_d   = frc_q;
            cnt_d      = C_SETTLE_LOAD;
            state_d    = ST_SETTLE;
         end

         ST_SETTLE: begin
            if (cnt_q == C_CNT_ZERO) begin
               done_d     = 1'b1;
               selforce_d = 1'b0;
               if (C_SKIP_DWELL) begin
                  state_d = ST_IDLE;
                  cnt_d   = C_CNT_ZERO;
               end else begin
                  state_d = ST_DWELL;
                  cnt_d   = C_DWELL_LOAD;
               end
            end else begin
               cnt_d = cnt_q - C_CNT_ONE;
            end
         end

         ST_DWELL: begin
            // Counter is loaded with DWELL_CYCLES on entry; leaving when it
            // reaches one gives exactly DWELL_CYCLES cycles in this state.
            // A zero count is treated the same way so it can never wrap.
            if (cnt_q <= C_CNT_ONE) begin
               cnt_d   = C_CNT_ZERO;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - C_CNT_ONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = C_CNT_ZERO;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= C_CNT_ZERO;
         sel_q      <= INIT_SEL;
         selforce_q <= 1'b0;
         done_q     <= 1'b0;
         forced_q   <= 1'b0;
         tgt_q      <= INIT_SEL;
         frc_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         selforce_q <= selforce_d;
         done_q     <= done_d;
         forced_q   <= forced_d;
         tgt_q      <= tgt_d;
         frc_q      <= frc_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs (ready/busy decode state only, no path from req_valid_i)
   // -------------------------------------------------------------------------
   assign req_ready_o    = (state_q == ST_IDLE);
   assign busy_o         = (state_q != ST_IDLE);
   assign dcs_sel_o      = sel_q;
   assign dcs_selforce_o = selforce_q;
   assign done_o         = done_q;
   assign forced_o       = forced_q;

endmodule
`default_nettype wire

// File: tb/tb_dcs_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcs_sel_ctrl
// Purpose  : Self-checking bench for dcs_sel_ctrl. Expected completions are
//            queued when a request is accepted and compared when done fires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcs_sel_ctrl;

   localparam int   SETTLE   = 8;
   localparam int   DWELL    = 16;
   localparam int   CNT_W    = 8;
   localparam logic INIT_SEL = 1'b0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req_valid = 1'b0;
   logic req_sel = 1'b0;
   logic req_force = 1'b0;
   logic clk0_alive = 1'b1;
   logic clk1_alive = 1'b1;
   logic req_ready;
   logic dcs_sel;
   logic dcs_selforce;
   logic busy;
   logic done;
   logic forced;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic sel;
      logic frc;
      int   lat;   // edges from accept edge until done is visible
   } exp_t;

   exp_t sb[$];
   logic m_sel = INIT_SEL;

   always #5 clk = ~clk;

   dcs_sel_ctrl #(
      .SETTLE_CYCLES (SETTLE),
      .DWELL_CYCLES  (DWELL),
      .CNT_W         (CNT_W),
      .INIT_SEL      (INIT_SEL)
   ) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_sel_i      (req_sel),
      .req_force_i    (req_force),
      .clk0_alive_i   (clk0_alive),
      .clk1_alive_i   (clk1_alive),
      .dcs_sel_o      (dcs_sel),
      .dcs_selforce_o (dcs_selforce),
      .busy_o         (busy),
      .done_o         (done),
      .forced_o       (forced)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model of one accept: push the expected completion and track
   // which clock the DCS should be on afterwards.
   task automatic model_push(input logic sel, input logic frc);
      exp_t e;
      logic alive_t;
      logic alive_c;
      logic f;
      alive_t = sel   ? clk1_alive : clk0_alive;
      alive_c = m_sel ? clk1_alive : clk0_alive;
      f = frc | !alive_t | !alive_c;
      e.sel = sel;
      e.frc = f;
      e.lat = (sel == m_sel && !f) ? 0 : SETTLE + 1;
      sb.push_back(e);
      m_sel = sel;
   endtask

   // Present a request, wait (bounded) for ready, then cross the accept edge.
   task automatic issue(input logic sel, input logic frc, output bit ok);
      ok = 1'b0;
      req_sel = sel;
      req_force = frc;
      req_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (ok) begin
         model_push(sel, frc);
         tick();
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input int start, output int lat, output bit ok);
      lat = start;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         tick();
         lat++;
      end
   endtask

   task automatic wait_ready(output int r, output bit extra_done);
      r = 0;
      extra_done = 1'b0;
      while (!req_ready && r < 200) begin
         tick();
         r++;
         if (done) extra_done = 1'b1;
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++;
      if (dcs_sel !== INIT_SEL || dcs_selforce !== 1'b0 || busy !== 1'b0 ||
          req_ready !== 1'b1 || done !== 1'b0 || forced !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold: sel=%b sf=%b busy=%b rdy=%b done=%b forced=%b, required %b 0 0 1 0 0",
                  dcs_sel, dcs_selforce, busy, req_ready, done, forced, INIT_SEL);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (dcs_sel !== INIT_SEL || busy !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release: sel=%b busy=%b rdy=%b, required %b 0 1",
                  dcs_sel, busy, req_ready, INIT_SEL);
      end
   endtask

   task automatic test_glitch_free();
      bit ok;
      int lat;
      int r;
      bit extra;
      exp_t e;
      clk0_alive = 1'b1;
      clk1_alive = 1'b1;
      issue(1'b1, 1'b0, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL gf_accept: ready never seen, required accept");
      end
      // Accept edge N: SEL must not move yet.
      checks++;
      if (dcs_sel !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
         failures++;
         $display("FAIL gf_at_accept: sel=%b busy=%b rdy=%b, required 0 1 0", dcs_sel, busy, req_ready);
      end
      tick();
      checks++;
      if (dcs_sel !== 1'b1 || dcs_selforce !== 1'b0) begin
         failures++;
         $display("FAIL gf_sel_n1: sel=%b sf=%b, required 1 0", dcs_sel, dcs_selforce);
      end
      wait_done(1, lat, ok);
      checks++;
      if (!ok || sb.size() == 0) begin
         failures++;
         $display("FAIL gf_done_timeout: done not seen (ok=%0d queued=%0d), required done", ok, sb.size());
      end else begin
         e = sb.pop_front();
         checks++;
         if (lat != e.lat || dcs_sel !== e.sel || forced !== e.frc || dcs_selforce !== 1'b0) begin
            failures++;
            $display("FAIL gf_done: lat=%0d sel=%b forced=%b sf=%b, required %0d %b %b 0",
                     lat, dcs_sel, forced, dcs_selforce, e.lat, e.sel, e.frc);
         end
      end
      wait_ready(r, extra);
      checks++;
      if (r != DWELL || extra) begin
         failures++;
         $display("FAIL gf_dwell: ready after %0d cycles (extra done=%0d), required %0d and no extra done",
                  r, extra, DWELL);
      end
   endtask

   task automatic test_noop();
      bit ok;
      int lat;
      int r;
      bit extra;
      exp_t e;
      logic cur;
      cur = m_sel;
      issue(cur, 1'b0, ok);
      wait_done(0, lat, ok);
      checks++;
      if (!ok || sb.size() == 0) begin
         failures++;
         $display("FAIL noop_done_timeout: done not seen, required done");
      end else begin
         e = sb.pop_front();
         checks++;
         if (lat != e.lat || dcs_sel !== cur || dcs_selforce !== 1'b0 || forced !== 1'b0) begin
            failures++;
            $display("FAIL noop_done: lat=%0d sel=%b sf=%b forced=%b, required %0d %b 0 0",
                     lat, dcs_sel, dcs_selforce, forced, e.lat, cur);
         end
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b1 || dcs_sel !== cur) begin
         failures++;
         $display("FAIL noop_dwell: done=%b busy=%b sel=%b, required 0 1 %b", done, busy, dcs_sel, cur);
      end
      wait_ready(r, extra);
      // Dwell starts at the accept edge; one edge has already passed.
      checks++;
      if (r != DWELL - 1 || extra) begin
         failures++;
         $display("FAIL noop_ready: ready after %0d (extra=%0d), required %0d", r, extra, DWELL - 1);
      end
   endtask

   task automatic test_back_to_back();
      logic a;
      int t;
      int done_at;
      int ready_at;
      int lat;
      bit ok;
      bit early;
      exp_t e;
      a = ~m_sel;
      req_sel = a;
      req_force = 1'b0;
      req_valid = 1'b1;
      for (int i = 0; i < 100 && !req_ready; i++) tick();
      model_push(a, 1'b0);
      tick();
      req_sel = ~a;          // second request, valid stays high
      t = 0;
      done_at = -1;
      ready_at = -1;
      early = 1'b0;
      while (t < 200 && ready_at < 0) begin
         tick();
         t++;
         if (done && done_at < 0) begin
            done_at = t;
            if (sb.size() != 0) begin
               e = sb.pop_front();
               checks++;
               if (dcs_sel !== e.sel || forced !== e.frc) begin
                  failures++;
                  $display("FAIL b2b_first_done: sel=%b forced=%b, required %b %b", dcs_sel, forced, e.sel, e.frc);
               end
            end
         end
         if (t > 1 && dcs_sel !== a) early = 1'b1;
         if (req_ready) ready_at = t;
      end
      checks++;
      if (done_at != SETTLE + 1 || early) begin
         failures++;
         $display("FAIL b2b_first: done at %0d (early accept=%0d), required %0d and none", done_at, early, SETTLE + 1);
      end
      checks++;
      if (ready_at - done_at != DWELL) begin
         failures++;
         $display("FAIL b2b_gap: ready %0d cycles after done, required %0d", ready_at - done_at, DWELL);
      end
      model_push(~a, 1'b0);
      tick();
      req_valid = 1'b0;
      wait_done(0, lat, ok);
      checks++;
      if (!ok || sb.size() == 0) begin
         failures++;
         $display("FAIL b2b_second_timeout: done not seen, required done");
      end else begin
         e = sb.pop_front();
         checks++;
         if (lat != e.lat || dcs_sel !== e.sel) begin
            failures++;
            $display("FAIL b2b_second: lat=%0d sel=%b, required %0d %b", lat, dcs_sel, e.lat, e.sel);
         end
      end
      wait_ready(t, ok);
   endtask

   task automatic test_dead_target();
      bit ok;
      int lat;
      int r;
      int hi;
      bit extra;
      exp_t e;
      if (m_sel !== 1'b0) begin
         issue(1'b0, 1'b0, ok);
         wait_done(0, lat, ok);
         if (sb.size() != 0) e = sb.pop_front();
         wait_ready(r, extra);
      end
      clk1_alive = 1'b0;
      issue(1'b1, 1'b0, ok);
      tick();
      hi = 0;
      for (int k = 1; k <= 8; k++) begin
         if (dcs_selforce === 1'b1) hi++;
         if (k == 3) clk1_alive = 1'b1;   // late revival must not matter
         if (k < 8) tick();
      end
      checks++;
      if (hi != SETTLE || done !== 1'b0) begin
         failures++;
         $display("FAIL dead_selforce: selforce high %0d cycles done=%b, required %0d and 0", hi, done, SETTLE);
      end
      tick();
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL dead_queue: no expected entry, required one");
      end else begin
         e = sb.pop_front();
         checks++;
         if (done !== 1'b1 || dcs_selforce !== 1'b0 || forced !== e.frc || dcs_sel !== e.sel) begin
            failures++;
            $display("FAIL dead_done: done=%b sf=%b forced=%b sel=%b, required 1 0 %b %b",
                     done, dcs_selforce, forced, dcs_sel, e.frc, e.sel);
         end
      end
      wait_ready(r, extra);
      checks++;
      if (forced !== 1'b1) begin
         failures++;
         $display("FAIL dead_sticky: forced=%b, required 1", forced);
      end
      issue(1'b0, 1'b0, ok);
      checks++;
      if (forced !== 1'b0) begin
         failures++;
         $display("FAIL dead_clear: forced=%b after accept, required 0", forced);
      end
      wait_done(0, lat, ok);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         checks++;
         if (!ok || forced !== e.frc || dcs_sel !== e.sel) begin
            failures++;
            $display("FAIL dead_next: ok=%0d forced=%b sel=%b, required 1 %b %b", ok, forced, dcs_sel, e.frc, e.sel);
         end
      end
      wait_ready(r, extra);
   endtask

   task automatic test_reset_mid_settle();
      bit ok;
      bit seen;
      issue(~m_sel, 1'b1, ok);
      repeat (3) tick();
      checks++;
      if (dcs_selforce !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_pre: sf=%b busy=%b, required 1 1", dcs_selforce, busy);
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if (dcs_sel !== INIT_SEL || dcs_selforce !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || forced !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid: sel=%b sf=%b busy=%b done=%b forced=%b rdy=%b, required %b 0 0 0 0 1",
                  dcs_sel, dcs_selforce, busy, done, forced, req_ready, INIT_SEL);
      end
      sb.delete();
      m_sel = INIT_SEL;
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         tick();
         if (done) seen = 1'b1;
      end
      checks++;
      if (seen || busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_after: done seen=%0d busy=%b, required 0 0", seen, busy);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_glitch_free();
      test_noop();
      test_back_to_back();
      test_dead_target();
      test_reset_mid_settle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
